// File: rtl/usb_fifo_arbiter.sv
// usb_fifo_arbiter: sequences and shares an FT245-style USB FIFO bus between three requesters
// (host-command receive, command-reply transmit and the recording data stream). This block
// owns all RD/WR strobe timing, so upstream logic sees only simple byte handshakes.
//
// Ports:
//   clk_i, rst_ni            system clock (50 MHz); asynchronous active-low reset
//   ena_i                    global enable: 0 blocks new grants, an in-flight transfer completes
//   rxf_i, txe_i             chip flags (active low); each passes through a 2-flop synchroniser
//   d_in_i / d_out_o         chip data bus in / out; ena_data_out_o is the tristate enable
//   rd_o (active low)        read strobe;  wr_o (active high, chip latches on falling edge)
//   rx_data_o, rx_valid_o    last received byte with a one-cycle "new" pulse
//   reply_req_i/_byte_i      pending reply byte (level, held until reply_ack_o pulses)
//   tx_data_i/_valid_i       recording stream byte; tx_ready_o completes the handshake
//   busy_o                   FSM is not idle
//
// Optional feature macro: USB_ARB_FAIR_EN. When defined, receive and write (reply+data as one
// class, reply first within it) alternate through a last-grant flag whenever both are pending.
// When undefined, strict priority applies: receive, then reply, then data.
module usb_fifo_arbiter #(
  parameter int unsigned RdLowCyc  = 3,  // 1..15
  parameter int unsigned WrHighCyc = 3,  // 1..15
  parameter int unsigned GapCyc    = 3   // 2..15
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ena_i,
  input  logic       rxf_i,
  input  logic       txe_i,
  input  logic [7:0] d_in_i,
  output logic [7:0] d_out_o,
  output logic       ena_data_out_o,
  output logic       rd_o,
  output logic       wr_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       reply_req_i,
  input  logic [7:0] reply_byte_i,
  output logic       reply_ack_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StRdStrobe,
    StRdDone,
    StWrSetup,
    StWrStrobe,
    StWrHold,
    StGap
  } state_e;

  localparam logic [3:0] RdLoad  = 4'(RdLowCyc - 1);
  localparam logic [3:0] WrLoad  = 4'(WrHighCyc - 1);
  localparam logic [3:0] GapLoad = 4'(GapCyc - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] d_out_q, d_out_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       is_reply_q, is_reply_d;

  // Strobe/status outputs are registered from the next state so the pins never glitch.
  logic rd_q, wr_q, oe_q, rx_valid_q, reply_ack_q, busy_q;

  // Flag synchronisers; reset to 1 so the flags read as inactive.
  logic [1:0] rxf_sync_q, txe_sync_q;
  logic       rxf_s, txe_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxf_sync_q <= 2'b11;
      txe_sync_q <= 2'b11;
    end else begin
      rxf_sync_q <= {rxf_sync_q[0], rxf_i};
      txe_sync_q <= {txe_sync_q[0], txe_i};
    end
  end

  assign rxf_s = rxf_sync_q[1];
  assign txe_s = txe_sync_q[1];

  // Grant arbitration; only meaningful in StIdle.
  logic rx_pend, wr_pend, pick_rx, grant_rx, grant_wr, grant_reply;

  assign rx_pend = ~rxf_s;
  assign wr_pend = ~txe_s & (reply_req_i | tx_valid_i);

`ifdef USB_ARB_FAIR_EN
  // Set when the most recent grant went to the receive path.
  logic last_rx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_rx_q <= 1'b0;
    end else if (grant_rx || grant_wr) begin
      last_rx_q <= grant_rx;
    end
  end

  assign pick_rx = rx_pend & (~wr_pend | ~last_rx_q);
`else
  assign pick_rx = rx_pend;
`endif

  assign grant_rx    = ena_i & (state_q == StIdle) & pick_rx;
  assign grant_wr    = ena_i & (state_q == StIdle) & wr_pend & ~pick_rx;
  assign grant_reply = grant_wr & reply_req_i;

  // Stream byte is taken only in the cycle its write is granted.
  assign tx_ready_o = grant_wr & ~reply_req_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_out_d    = d_out_q;
    rx_data_d  = rx_data_q;
    is_reply_d = is_reply_q;
    unique case (state_q)
      StIdle: begin
        if (grant_rx) begin
          state_d = StRdStrobe;
          cnt_d   = RdLoad;
        end else if (grant_wr) begin
          state_d    = StWrSetup;
          d_out_d    = grant_reply ? reply_byte_i : tx_data_i;
          is_reply_d = grant_reply;
        end
      end
      StRdStrobe: begin
        if (cnt_q == 4'd0) begin
          rx_data_d = d_in_i;  // sampled on the last RD-low cycle
          state_d   = StRdDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRdDone: begin
        state_d = StGap;
        cnt_d   = GapLoad;
      end
      StWrSetup: begin
        state_d = StWrStrobe;
        cnt_d   = WrLoad;
      end
      StWrStrobe: begin
        if (cnt_q == 4'd0) begin
          state_d = StWrHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrHold: begin
        state_d = StGap;
        cnt_d   = GapLoad;
      end
      StGap: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      d_out_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      is_reply_q  <= 1'b0;
      rd_q        <= 1'b1;
      wr_q        <= 1'b0;
      oe_q        <= 1'b0;
      rx_valid_q  <= 1'b0;
      reply_ack_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_out_q     <= d_out_d;
      rx_data_q   <= rx_data_d;
      is_reply_q  <= is_reply_d;
      rd_q        <= (state_d != StRdStrobe);
      wr_q        <= (state_d == StWrStrobe);
      oe_q        <= (state_d == StWrSetup) || (state_d == StWrStrobe) || (state_d == StWrHold);
      rx_valid_q  <= (state_d == StRdDone);
      reply_ack_q <= (state_d == StWrHold) && is_reply_d;
      busy_q      <= (state_d != StIdle);
    end
  end

  assign d_out_o        = d_out_q;
  assign ena_data_out_o = oe_q;
  assign rd_o           = rd_q;
  assign wr_o           = wr_q;
  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign reply_ack_o    = reply_ack_q;
  assign busy_o         = busy_q;

endmodule
